// File: rtl/iomem_interconnect.sv
// iomem_interconnect: picosoc iomem master port to NUM_SLAVES peripherals.
//   Decodes addr[31:24] against per-slave page numbers (slice i of SLAVE_PAGES
//   is the page of slave i, lowest index wins on duplicates). It forwards one
//   registered request at a time and registers the returned rdata. Unmapped
//   pages complete with rdata 0.
// Optional feature: define IOMEM_INTERCONNECT_TIMEOUT_EN to abort slaves that
//   stay silent for TIMEOUT_CYCLES ACTIVE cycles (rdata ERR_RDATA, err_irq pulse).
//   Without it err_irq/err_addr are held 0. The ports are the same in both builds.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   m_valid/m_wstrb/m_addr/m_wdata  master request (wstrb 0 = read)
//   m_ready/m_rdata                 one-cycle completion pulse + read data
//   s_valid[NUM_SLAVES]             one-hot request to the selected slave
//   s_wstrb/s_addr/s_wdata          registered request, shared by all slaves
//   s_ready[NUM_SLAVES], s_rdata    per-slave ready, 32-bit rdata slices
//   err_irq/err_addr                abort pulse + address of last aborted access

module iomem_page_match (
  input  logic [7:0] page,
  input  logic [7:0] addr_page,
  output logic       hit
);
  assign hit = (addr_page == page);
endmodule

module iomem_interconnect #(
  parameter int                      NUM_SLAVES     = 4,
  parameter logic [8*NUM_SLAVES-1:0] SLAVE_PAGES    = {8'h07, 8'h06, 8'h05, 8'h03},
  parameter int                      TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     m_valid,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic                     m_ready,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic                     err_irq,
  output logic [31:0]              err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("iomem_interconnect: NUM_SLAVES must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iomem_req_t;

  state_t                  state, state_nxt;
  iomem_req_t              req_q;
  logic [IDX_W-1:0]        sel, hit_idx;
  logic                    miss;
  logic [NUM_SLAVES-1:0]   page_hit;
  logic                    page_any;
  logic                    sel_ready;
  logic [31:0]             sel_rdata;
  logic                    timeout;

  // Per-slave page comparators.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
    iomem_page_match u_match (
      .page      (SLAVE_PAGES[8*i +: 8]),
      .addr_page (m_addr[31:24]),
      .hit       (page_hit[i])
    );
  end

  // Scan from the top down so the lowest matching index is the one left.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (page_hit[i]) hit_idx = IDX_W'(i);
    end
  end

  assign page_any  = |page_hit;
  assign sel_ready = s_ready[sel];
  assign sel_rdata = s_rdata[32*sel +: 32];

`ifdef IOMEM_INTERCONNECT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // Counts ACTIVE cycles; zero in every other state, so the first ACTIVE
  // cycle sees 0 and the TIMEOUT_CYCLES-th sees TIMEOUT_CYCLES-1.
  always_ff @(posedge clk) begin
    if (reset || state != ACTIVE) cnt <= '0;
    else                          cnt <= cnt + CNT_W'(1);
  end

  assign timeout = !miss && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Unmapped pages still pass through one ACTIVE cycle (with no s_valid)
  // so mapped and unmapped accesses share the same completion timing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_valid) state_nxt = ACTIVE;
      ACTIVE:  if (miss || sel_ready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_valid = '0;
    if (state == ACTIVE && !miss) s_valid[sel] = 1'b1;
  end

  assign m_ready = (state == RESP);
  assign s_wstrb = req_q.wstrb;
  assign s_addr  = req_q.addr;
  assign s_wdata = req_q.wdata;

  // Request/response datapath. s_* only change when a mapped access is
  // accepted, so they stay stable for the whole ACTIVE phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q    <= '0;
      sel      <= '0;
      miss     <= 1'b0;
      m_rdata  <= '0;
      err_irq  <= 1'b0;
      err_addr <= '0;
    end else begin
      err_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            miss <= !page_any;
            if (page_any) begin
              req_q <= '{wstrb: m_wstrb, addr: m_addr, wdata: m_wdata};
              sel   <= hit_idx;
            end
          end
        end
        ACTIVE: begin
          if (miss) begin
            m_rdata <= '0;
          end else if (sel_ready) begin
            m_rdata <= sel_rdata;
          end else if (timeout) begin
            m_rdata  <= ERR_RDATA;
            err_irq  <= 1'b1;
            err_addr <= req_q.addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_interconnect.sv
module tb_iomem_interconnect;

  localparam int          NS  = 4;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_valid, m_valid2;
  logic [3:0]    m_wstrb;
  logic [31:0]   m_addr, m_wdata;
  logic          m_ready, m_ready2;
  logic [31:0]   m_rdata, m_rdata2;
  logic [NS-1:0] s_valid, s_valid2;
  logic [3:0]    s_wstrb, s_wstrb2;
  logic [31:0]   s_addr, s_addr2, s_wdata, s_wdata2;
  logic [NS-1:0] s_ready, s_ready2;
  logic [32*NS-1:0] s_rdata, s_rdata2;
  logic          err_irq, err_irq2;
  logic [31:0]   err_addr, err_addr2;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Default pages: slave0=0x03, slave1=0x05, slave2=0x06, slave3=0x07.
  iomem_interconnect #(.NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata), .s_valid(s_valid),
    .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready),
    .s_rdata(s_rdata), .err_irq(err_irq), .err_addr(err_addr)
  );

  // Slices 0 and 1 both claim page 0x05.
  iomem_interconnect #(.NUM_SLAVES(NS), .SLAVE_PAGES({8'h07, 8'h06, 8'h05, 8'h05}),
                       .TIMEOUT_CYCLES(TO)) dut_dup (
    .clk(clk), .reset(reset), .m_valid(m_valid2), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready2), .m_rdata(m_rdata2), .s_valid(s_valid2),
    .s_wstrb(s_wstrb2), .s_addr(s_addr2), .s_wdata(s_wdata2), .s_ready(s_ready2),
    .s_rdata(s_rdata2), .err_irq(err_irq2), .err_addr(err_addr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access, started in an IDLE cycle (cycle 0). sel<0 = unmapped page;
  // rdy = cycle the slave raises s_ready, 0 = silent slave (abort expected).
  // Returns in the IDLE cycle directly after the completion.
  task automatic do_access(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int sel, input int rdy,
                           input logic [31:0] rdata, input bit noise);
    logic [31:0]   exp_rd, got_rd;
    logic [NS-1:0] exp_sv;
    int  done_cyc, last_act;
    bit  got, abort;
    abort = (sel >= 0 && rdy == 0);
    if (sel < 0)    begin exp_rd = 32'h0; last_act = 0;   done_cyc = 2;       end
    else if (abort) begin exp_rd = ERR;   last_act = TO;  done_cyc = TO + 1;  end
    else            begin exp_rd = rdata; last_act = rdy; done_cyc = rdy + 1; end
    exp_q.push_back(exp_rd);
    m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata;
    got = 1'b0;
    for (int c = 1; c <= TO + 4 && !got; c++) begin
      tick();
      m_valid = 1'b0; m_addr = ~addr; m_wstrb = ~wstrb; m_wdata = ~wdata;
      exp_sv = '0;
      if (sel >= 0 && c <= last_act) exp_sv[sel] = 1'b1;
      checks++;
      if (s_valid !== exp_sv) begin
        failures++;
        $display("FAIL s_valid addr=%h cyc=%0d got=%b exp=%b", addr, c, s_valid, exp_sv);
      end
      if (sel >= 0 && c <= last_act) begin
        checks++;
        if ({s_wstrb, s_addr, s_wdata} !== {wstrb, addr, wdata}) begin
          failures++;
          $display("FAIL s_hold cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c, s_wstrb, s_addr,
                   s_wdata, wstrb, addr, wdata);
        end
      end
      checks++;
      if (err_irq !== (abort && c == done_cyc)) begin
        failures++;
        $display("FAIL err_irq addr=%h cyc=%0d got=%b", addr, c, err_irq);
      end
      if (m_ready === 1'b1) begin
        got = 1'b1;
        checks++;
        if (c != done_cyc) begin
          failures++;
          $display("FAIL m_ready_cycle addr=%h got=%0d exp=%0d", addr, c, done_cyc);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL m_rdata addr=%h unexpected completion, scoreboard empty", addr);
        end else begin
          got_rd = exp_q.pop_front();
          if (m_rdata !== got_rd) begin
            failures++;
            $display("FAIL m_rdata addr=%h got=%h exp=%h", addr, m_rdata, got_rd);
          end
        end
      end
      // Slave side for this cycle; non-selected slaves may chatter.
      s_ready = noise ? {NS{1'b1}} : '0;
      s_rdata = {NS{32'hBAD0_BAD0}};
      if (sel >= 0) s_ready[sel] = (c == rdy);
      if (sel >= 0 && c == rdy) s_rdata[32*sel +: 32] = rdata;
    end
    s_ready = '0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL no_m_ready addr=%h exp_cycle=%0d", addr, done_cyc);
      exp_q.delete();
    end
    tick();
    checks++;
    if (m_ready !== 1'b0 || m_rdata !== exp_rd || err_irq !== 1'b0) begin
      failures++;
      $display("FAIL after_resp addr=%h m_ready=%b m_rdata=%h exp_rdata=%h err_irq=%b",
               addr, m_ready, m_rdata, exp_rd, err_irq);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m_valid = 1'b0; m_valid2 = 1'b0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
    s_ready = '0; s_ready2 = '0; s_rdata = '0; s_rdata2 = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (m_ready !== 1'b0 || m_rdata !== 32'h0 || s_valid !== '0) begin
      failures++;
      $display("FAIL reset_m got m_ready=%b m_rdata=%h s_valid=%b exp 0", m_ready, m_rdata, s_valid);
    end
    checks++;
    if (s_wstrb !== 4'h0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_s got %h/%h/%h exp 0", s_wstrb, s_addr, s_wdata);
    end
    checks++;
    if (err_irq !== 1'b0 || err_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_err got err_irq=%b err_addr=%h exp 0", err_irq, err_addr);
    end
  endtask

  task automatic test_read();
    // Page 0x05 is slice 1 of the default page map.
    do_access(32'h0500_0010, 4'h0, 32'h0, 1, 3, 32'h1234_5678, 1'b0);
    do_access(32'h0600_0010, 4'h0, 32'h0, 2, 3, 32'h1234_5678, 1'b0);
    do_access(32'h07AB_CDEF, 4'h0, 32'h0, 3, 1, 32'h0F0F_0F0F, 1'b0);
  endtask

  task automatic test_write();
    do_access(32'h0300_0004, 4'hF, 32'hA5A5_A5A5, 0, 5, 32'h0000_0011, 1'b0);
    do_access(32'h0300_0008, 4'h3, 32'h0000_BEEF, 0, 2, 32'h8000_0001, 1'b1);
  endtask

  task automatic test_unmapped();
    do_access(32'h0900_0000, 4'h0, 32'h0, -1, 0, 32'h0, 1'b0);
    do_access(32'hFF00_1234, 4'hF, 32'h5555_AAAA, -1, 0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_access(32'h0600_0100, 4'h0, 32'h0, 2, 1, 32'h1111_2222, 1'b1);
    do_access(32'h0900_0000, 4'h0, 32'h0, -1, 0, 32'h0, 1'b1);
    do_access(32'h0500_0200, 4'h0, 32'h0, 1, 4, 32'h3333_4444, 1'b1);
    do_access(32'h0300_0300, 4'hC, 32'h7777_8888, 0, 1, 32'h5555_6666, 1'b1);
  endtask

  task automatic test_dup_pages();
    logic [31:0] e;
    m_addr = 32'h0512_3456; m_wstrb = 4'h0; m_valid2 = 1'b1;
    exp_q.push_back(32'hCAFE_0001);
    tick();
    m_valid2 = 1'b0;
    checks++;
    if (s_valid2 !== 4'b0001) begin
      failures++;
      $display("FAIL dup_s_valid got=%b exp=0001", s_valid2);
    end
    s_ready2 = 4'b0011;
    s_rdata2 = {32'h0, 32'h0, 32'h0BAD_0BAD, 32'hCAFE_0001};
    tick();
    s_ready2 = '0;
    checks++;
    if (m_ready2 !== 1'b1) begin
      failures++;
      $display("FAIL dup_m_ready got=%b exp=1", m_ready2);
    end
    e = exp_q.pop_front();
    checks++;
    if (m_rdata2 !== e) begin
      failures++;
      $display("FAIL dup_m_rdata got=%h exp=%h", m_rdata2, e);
    end
    tick();
    checks++;
    if (m_ready2 !== 1'b0 || s_valid2 !== '0) begin
      failures++;
      $display("FAIL dup_after got m_ready=%b s_valid=%b exp 0", m_ready2, s_valid2);
    end
  endtask

`ifdef IOMEM_INTERCONNECT_TIMEOUT_EN
  task automatic test_timeout();
    do_access(32'h0600_0040, 4'h0, 32'h0, 2, 0, 32'h0, 1'b1);
    checks++;
    if (err_addr !== 32'h0600_0040) begin
      failures++;
      $display("FAIL err_addr got=%h exp=06000040", err_addr);
    end
    // s_ready in the last allowed cycle is a normal completion.
    do_access(32'h0700_0044, 4'h0, 32'h0, 3, TO, 32'h2468_ACE0, 1'b0);
    checks++;
    if (err_addr !== 32'h0600_0040) begin
      failures++;
      $display("FAIL err_addr_hold got=%h exp=06000040", err_addr);
    end
  endtask
`else
  task automatic test_no_timeout();
    m_valid = 1'b1; m_addr = 32'h0600_0040; m_wstrb = 4'h0;
    tick();
    m_valid = 1'b0;
    for (int c = 1; c <= 3 * TO; c++) begin
      checks++;
      if (m_ready !== 1'b0 || s_valid !== 4'b0100 || err_irq !== 1'b0 || err_addr !== 32'h0) begin
        failures++;
        $display("FAIL silent_wait cyc=%0d m_ready=%b s_valid=%b err_irq=%b err_addr=%h",
                 c, m_ready, s_valid, err_irq, err_addr);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_active();
    m_valid = 1'b1; m_addr = 32'h0700_0020; m_wstrb = 4'h0;
    tick();
    m_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (s_valid !== 4'b1000) begin
      failures++;
      $display("FAIL mid_active_s_valid got=%b exp=1000", s_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (s_valid !== '0 || m_ready !== 1'b0 || m_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset got s_valid=%b m_ready=%b m_rdata=%h exp 0", s_valid, m_ready, m_rdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (m_ready !== 1'b0 || s_valid !== '0) begin
        failures++;
        $display("FAIL post_reset_idle cyc=%0d m_ready=%b s_valid=%b exp 0", c, m_ready, s_valid);
      end
    end
    do_access(32'h0700_0020, 4'h0, 32'h0, 3, 2, 32'h7777_0000, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_back_to_back();
    test_dup_pages();
`ifdef IOMEM_INTERCONNECT_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
